// File: rtl/cpu_control_unit.sv
// Multi-cycle instruction controller for the 16-bit processor.
// Fetches from ROM, holds the IR, and sequences RAM, register file and ALU.
module cpu_control_unit #(
   parameter int PcBits    = 7,
   parameter int DAddrBits = 8,
   parameter int RegBits   = 4
) (
   input  logic                 Clock,
   input  logic                 ResetN,
   input  logic [15:0]          Instr,
   output logic [PcBits-1:0]    PC,
   output logic [15:0]          IR,
   output logic [3:0]           OutState,
   output logic [DAddrBits-1:0] D_Addr,
   output logic                 D_Wr,
   output logic                 RF_s,
   output logic [RegBits-1:0]   RF_W_addr,
   output logic                 RF_W_en,
   output logic [RegBits-1:0]   RF_Ra_addr,
   output logic [RegBits-1:0]   RF_Rb_addr,
   output logic [2:0]           ALU_s0
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_STORE  = 4'd4,
      S_LOADA  = 4'd5,
      S_LOADB  = 4'd6,
      S_ALU    = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [3:0] opcode;
   logic       op_store;
   logic       op_load;
   logic       op_halt;
   logic       op_add;
   logic       op_sub;
   logic       op_xor;
   logic       op_or;
   logic       op_and;
   logic       op_inc;
   logic       op_alu;
   logic [2:0] alu_fn;

   assign opcode   = IR[15:12];
   assign op_store = (opcode == 4'b0001);
   assign op_load  = (opcode == 4'b0010);
   assign op_add   = (opcode == 4'b0011);
   assign op_sub   = (opcode == 4'b0100);
   assign op_halt  = (opcode == 4'b0101);
   assign op_xor   = (opcode == 4'b0110);
   assign op_or    = (opcode == 4'b0111);
   assign op_and   = (opcode == 4'b1000);
   assign op_inc   = (opcode == 4'b1001);
   assign op_alu   = op_add | op_sub | op_xor
                   | op_or  | op_and | op_inc;

   always_comb begin
      alu_fn = 3'b000;
      unique case (1'b1)
         op_add:  alu_fn = 3'b001;
         op_sub:  alu_fn = 3'b010;
         op_xor:  alu_fn = 3'b100;
         op_or:   alu_fn = 3'b101;
         op_and:  alu_fn = 3'b110;
         op_inc:  alu_fn = 3'b111;
         default: alu_fn = 3'b000;
      endcase
   end

   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // PC and IR only move in Fetch, which also freezes them in Halt.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         PC <= '0;
         IR <= '0;
      end else if (state == S_FETCH) begin
         IR <= Instr;
         PC <= PC + PcBits'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_INIT:   state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            unique case (1'b1)
               op_store: state_nxt = S_STORE;
               op_load:  state_nxt = S_LOADA;
               op_alu:   state_nxt = S_ALU;
               op_halt:  state_nxt = S_HALT;
               default:  state_nxt = S_NOOP;
            endcase
         end
         S_NOOP:   state_nxt = S_FETCH;
         S_STORE:  state_nxt = S_FETCH;
         S_LOADA:  state_nxt = S_LOADB;
         S_LOADB:  state_nxt = S_FETCH;
         S_ALU:    state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      OutState   = state;
      D_Addr     = '0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_en    = 1'b0;
      ALU_s0     = 3'b000;
      RF_Ra_addr = RegBits'(IR[11:8]);
      RF_Rb_addr = RegBits'(IR[7:4]);
      RF_W_addr  = RegBits'(IR[3:0]);
      unique case (state)
         S_STORE: begin
            D_Addr = DAddrBits'(IR[7:0]);
            D_Wr   = 1'b1;
         end
         // RAM read data lands one cycle after the address.
         S_LOADA: begin
            D_Addr = DAddrBits'(IR[11:4]);
            RF_s   = 1'b1;
         end
         S_LOADB: begin
            D_Addr  = DAddrBits'(IR[11:4]);
            RF_s    = 1'b1;
            RF_W_en = 1'b1;
         end
         S_ALU: begin
            ALU_s0  = alu_fn;
            RF_W_en = 1'b1;
         end
         default: begin
            D_Addr = '0;
         end
      endcase
   end

endmodule
